// File: rtl/elevador_scheduler.sv
// SCAN floor-request scheduler: latches buttons, tracks floor from shaft pulses, drives motor/door.
// Optional ELEVADOR_WATCHDOG_EN adds a move watchdog that traps into a fault state until rst.
module elevador_scheduler #(
    parameter int unsigned N_FLOORS    = 4,
    parameter int unsigned DOOR_CYCLES = 50,
    parameter int unsigned WD_CYCLES   = 1000,
    localparam int unsigned FW         = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] boton,
    input  logic                sensor_piso,
    output logic                Motorsubir,
    output logic                Motorbajar,
    output logic                puerta_abierta,
    output logic [FW-1:0]       piso_actual,
    output logic [N_FLOORS-1:0] pendientes,
    output logic                falla
);

    // Door timer and watchdog never run together, so they share one counter.
    localparam int unsigned CntMax = (DOOR_CYCLES > WD_CYCLES) ? DOOR_CYCLES : WD_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StMoveUp   = 3'd1,
        StMoveDown = 3'd2,
        StDoorOpen = 3'd3,
        StFault    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [FW-1:0]       piso_q, piso_d;
    logic [N_FLOORS-1:0] pend_q, pend_d;
    logic                dir_q, dir_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                mup_q, mup_d, mdn_q, mdn_d, door_q, door_d;

    logic [N_FLOORS-1:0] req_all;
    logic [FW-1:0]       piso_up, piso_dn;
    logic                above, below, above_up, below_dn;

    always_comb begin
        req_all  = pend_q | boton;
        piso_up  = (piso_q == FW'(N_FLOORS - 1)) ? piso_q : piso_q + 1'b1;
        piso_dn  = (piso_q == '0) ? piso_q : piso_q - 1'b1;
        above    = 1'b0;
        below    = 1'b0;
        above_up = 1'b0;
        below_dn = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (FW'(i) > piso_q && pend_q[i]) above = 1'b1;
            if (FW'(i) < piso_q && pend_q[i]) below = 1'b1;
            if (FW'(i) > piso_up && req_all[i]) above_up = 1'b1;
            if (FW'(i) < piso_dn && req_all[i]) below_dn = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        piso_d  = piso_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        pend_d  = req_all;

        unique case (state_q)
            StIdle: begin
                if (boton[piso_q] || pend_q[piso_q]) begin
                    state_d = StDoorOpen;
                end else if (above && (dir_q || !below)) begin
                    state_d = StMoveUp;
                    dir_d   = 1'b1;
                    cnt_d   = '0;
                end else if (below) begin
                    state_d = StMoveDown;
                    dir_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StMoveUp: begin
                if (sensor_piso) begin
                    piso_d = piso_up;
                    cnt_d  = '0;
                    if (req_all[piso_up]) state_d = StDoorOpen;
                    else if (!above_up)   state_d = StIdle;
                end
`ifdef ELEVADOR_WATCHDOG_EN
                else if (cnt_q == CntW'(WD_CYCLES - 1)) state_d = StFault;
                else cnt_d = cnt_q + 1'b1;
`endif
            end
            StMoveDown: begin
                if (sensor_piso) begin
                    piso_d = piso_dn;
                    cnt_d  = '0;
                    if (req_all[piso_dn]) state_d = StDoorOpen;
                    else if (!below_dn)   state_d = StIdle;
                end
`ifdef ELEVADOR_WATCHDOG_EN
                else if (cnt_q == CntW'(WD_CYCLES - 1)) state_d = StFault;
                else cnt_d = cnt_q + 1'b1;
`endif
            end
            StDoorOpen: begin
                if (boton[piso_q])    cnt_d = CntW'(DOOR_CYCLES - 1);
                else if (cnt_q == '0) state_d = StIdle;
                else                  cnt_d = cnt_q - 1'b1;
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase

        // Arriving at a stop (or re-pressing while open) serves the current floor.
        if (state_d == StDoorOpen) begin
            pend_d[piso_d] = 1'b0;
            if (state_q != StDoorOpen) cnt_d = CntW'(DOOR_CYCLES - 1);
        end

        mup_d  = (state_d == StMoveUp);
        mdn_d  = (state_d == StMoveDown);
        door_d = (state_d == StDoorOpen);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            piso_q  <= '0;
            pend_q  <= '0;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
            mup_q   <= 1'b0;
            mdn_q   <= 1'b0;
            door_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            piso_q  <= piso_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            mup_q   <= mup_d;
            mdn_q   <= mdn_d;
            door_q  <= door_d;
        end
    end

`ifdef ELEVADOR_WATCHDOG_EN
    logic falla_q;
    always_ff @(posedge clk) begin
        if (rst) falla_q <= 1'b0;
        else     falla_q <= (state_d == StFault);
    end
    assign falla = falla_q;
`else
    assign falla = 1'b0;
`endif

    assign Motorsubir     = mup_q;
    assign Motorbajar     = mdn_q;
    assign puerta_abierta = door_q;
    assign piso_actual    = piso_q;
    assign pendientes     = pend_q;

endmodule
